// File: rtl/term_loopback_switch_matrix.sv
// term_loopback_switch_matrix
// South-terminal loopback switch matrix: every south-arriving wire group is
// turned back north. Each output wire has a 2-bit mode held in an active
// register that is loaded atomically from a serially filled shadow register.
// Optional macro TERM_SM_READBACK_EN: drive ConfigDataOut from the shadow MSB
// for daisy-chained readback; when undefined ConfigDataOut is tied to 0.
module term_loopback_switch_matrix #(
    parameter int W1  = 4,
    parameter int W2  = 8,
    parameter int W4  = 16,
    parameter int WW4 = 16
) (
    input  logic           UserCLK,
    input  logic           Reset,
    input  logic [W1-1:0]  S1END,
    input  logic [W2-1:0]  S2MID,
    input  logic [W2-1:0]  S2END,
    input  logic [W4-1:0]  S4END,
    input  logic [WW4-1:0] SS4END,
    output logic [W1-1:0]  N1BEG,
    output logic [W2-1:0]  N2BEG,
    output logic [W2-1:0]  N2BEGb,
    output logic [W4-1:0]  N4BEG,
    output logic [WW4-1:0] NN4BEG,
    input  logic           ConfigData,
    input  logic           ConfigShiftEn,
    input  logic           ConfigCommit,
    output logic           ConfigLoaded,
    output logic           ConfigErr,
    output logic           ConfigDataOut
);

    localparam int NUM_WIRES    = W1 + 2*W2 + W4 + WW4;
    localparam int NoConfigBits = 2 * NUM_WIRES;
    localparam int CNT_W        = $clog2(NoConfigBits + 2);
    // Base of each group in the global wire index
    localparam int B2M = W1;
    localparam int B2E = W1 + W2;
    localparam int B4  = W1 + 2*W2;
    localparam int BW4 = W1 + 2*W2 + W4;

    typedef enum logic [1:0] {
        MODE_REV      = 2'b00,
        MODE_STRAIGHT = 2'b01,
        MODE_REG_REV  = 2'b10,
        MODE_ZERO     = 2'b11
    } mode_t;

    logic [NoConfigBits-1:0] shadow;
    logic [NoConfigBits-1:0] active;
    logic [CNT_W-1:0]        bit_count;
    logic [NUM_WIRES-1:0]    straight_all;
    logic [NUM_WIRES-1:0]    reversed_all;
    logic [NUM_WIRES-1:0]    reversed_q;
    logic [NUM_WIRES-1:0]    route_all;

    // Global wire k: S1END[0] is k=0, SS4END[WW4-1] is the last wire
    assign straight_all = {SS4END, S4END, S2END, S2MID, S1END};

    // Per-group index reversal, placed at the same global positions
    always_comb begin
        // NOTE: give every combinationally assigned signal a default first so no path leaves it unassigned and infers a latch.
        reversed_all = '0;
        for (int i = 0; i < W1; i++)  reversed_all[i]       = S1END[W1-1-i];
        for (int i = 0; i < W2; i++)  reversed_all[B2M + i] = S2MID[W2-1-i];
        for (int i = 0; i < W2; i++)  reversed_all[B2E + i] = S2END[W2-1-i];
        for (int i = 0; i < W4; i++)  reversed_all[B4 + i]  = S4END[W4-1-i];
        for (int i = 0; i < WW4; i++) reversed_all[BW4 + i] = SS4END[WW4-1-i];
    end

    // Shadow shifting, bit counting and atomic commit; commit beats shift
    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            shadow       <= '0;
            active       <= '0;
            bit_count    <= '0;
            ConfigLoaded <= 1'b0;
            ConfigErr    <= 1'b0;
        end else if (ConfigCommit) begin
            // NOTE: non-blocking assignments so every register here samples pre-edge values, whatever the statement order.
            if (bit_count == CNT_W'(NoConfigBits)) begin
                active       <= shadow;
                ConfigLoaded <= 1'b1;
            end else begin
                ConfigErr <= 1'b1;
            end
            bit_count <= '0;
        end else if (ConfigShiftEn) begin
            shadow <= {shadow[NoConfigBits-2:0], ConfigData};
            if (bit_count != CNT_W'(NoConfigBits + 1)) begin
                bit_count <= bit_count + 1'b1;
            end
        end
    end

    // Registered reversed copy runs every cycle, whatever the modes
    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            reversed_q <= '0;
        end else begin
            reversed_q <= reversed_all;
        end
    end

    // Per-wire source selection from the active mode bits
    always_comb begin
        route_all = '0;
        for (int k = 0; k < NUM_WIRES; k++) begin
            case (active[2*k +: 2])
                MODE_REV:      route_all[k] = reversed_all[k];
                MODE_STRAIGHT: route_all[k] = straight_all[k];
                MODE_REG_REV:  route_all[k] = reversed_q[k];
                MODE_ZERO:     route_all[k] = 1'b0;
                default:       route_all[k] = 1'b0;
            endcase
        end
    end

    assign N1BEG  = route_all[W1-1:0];
    assign N2BEG  = route_all[B2M +: W2];
    assign N2BEGb = route_all[B2E +: W2];
    assign N4BEG  = route_all[B4 +: W4];
    assign NN4BEG = route_all[BW4 +: WW4];

`ifdef TERM_SM_READBACK_EN
    assign ConfigDataOut = shadow[NoConfigBits-1];
`else
    assign ConfigDataOut = 1'b0;
`endif

endmodule

// File: tb/tb_term_loopback_switch_matrix.sv
// Self-checking bench for term_loopback_switch_matrix: table vectors,
// directed configuration sequences and randomized traffic against a
// per-wire behavioural model.
module tb_term_loopback_switch_matrix;

    localparam int NW = 52;
    localparam int NB = 104;

    logic        UserCLK;
    logic        Reset;
    logic [3:0]  S1END;
    logic [7:0]  S2MID, S2END;
    logic [15:0] S4END, SS4END;
    logic [3:0]  N1BEG;
    logic [7:0]  N2BEG, N2BEGb;
    logic [15:0] N4BEG, NN4BEG;
    logic        ConfigData, ConfigShiftEn, ConfigCommit;
    logic        ConfigLoaded, ConfigErr, ConfigDataOut;

    term_loopback_switch_matrix dut (
        .UserCLK(UserCLK), .Reset(Reset),
        .S1END(S1END), .S2MID(S2MID), .S2END(S2END), .S4END(S4END), .SS4END(SS4END),
        .N1BEG(N1BEG), .N2BEG(N2BEG), .N2BEGb(N2BEGb), .N4BEG(N4BEG), .NN4BEG(NN4BEG),
        .ConfigData(ConfigData), .ConfigShiftEn(ConfigShiftEn), .ConfigCommit(ConfigCommit),
        .ConfigLoaded(ConfigLoaded), .ConfigErr(ConfigErr), .ConfigDataOut(ConfigDataOut)
    );

    initial UserCLK = 1'b0;
    always #5 UserCLK = ~UserCLK;

    int n_pass = 0;
    int n_total = 0;

    // Behavioural model state
    int          m_mode[NW];
    int          want[NW];
    logic [NB-1:0] m_shadow;
    int          m_count;
    logic        m_loaded, m_err;
    logic [3:0]  p1;
    logic [7:0]  p2m, p2e;
    logic [15:0] p4, pw4;

    typedef struct {
        int          mode;
        logic [3:0]  s1;
        logic [7:0]  s2m, s2e;
        logic [15:0] s4, ss4;
        logic [3:0]  e1;
        logic [7:0]  e2, e2b;
        logic [15:0] e4, ew4;
    } vec_t;
    vec_t tab[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Expected output of one group from the per-wire modes
    function automatic logic [15:0] exp_group(input int base, input int w,
                                             input logic [15:0] cur, input logic [15:0] prv);
        logic [15:0] r = '0;
        for (int i = 0; i < w; i++) begin
            case (m_mode[base + i])
                0: r[i] = cur[w-1-i];
                1: r[i] = cur[i];
                2: r[i] = prv[w-1-i];
                default: r[i] = 1'b0;
            endcase
        end
        return r;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ":N1BEG"},  32'(N1BEG),  32'(exp_group(0, 4, 16'(S1END), 16'(p1))));
        check({tag, ":N2BEG"},  32'(N2BEG),  32'(exp_group(4, 8, 16'(S2MID), 16'(p2m))));
        check({tag, ":N2BEGb"}, 32'(N2BEGb), 32'(exp_group(12, 8, 16'(S2END), 16'(p2e))));
        check({tag, ":N4BEG"},  32'(N4BEG),  32'(exp_group(20, 16, S4END, p4)));
        check({tag, ":NN4BEG"}, 32'(NN4BEG), 32'(exp_group(36, 16, SS4END, pw4)));
        check({tag, ":loaded"}, 32'(ConfigLoaded), 32'(m_loaded));
        check({tag, ":err"},    32'(ConfigErr),    32'(m_err));
`ifdef TERM_SM_READBACK_EN
        check({tag, ":dout"},   32'(ConfigDataOut), 32'(m_shadow[NB-1]));
`else
        check({tag, ":dout"},   32'(ConfigDataOut), 32'd0);
`endif
    endtask

    task automatic model_reset();
        for (int k = 0; k < NW; k++) m_mode[k] = 0;
        m_shadow = '0; m_count = 0; m_loaded = 1'b0; m_err = 1'b0;
        p1 = '0; p2m = '0; p2e = '0; p4 = '0; pw4 = '0;
    endtask

    // One clock: registered loopback captures the inputs present at the edge
    task automatic tick();
        p1 = S1END; p2m = S2MID; p2e = S2END; p4 = S4END; pw4 = SS4END;
        @(posedge UserCLK);
        #1;
    endtask

    task automatic shift_bit(input logic b);
        ConfigData = b; ConfigShiftEn = 1'b1;
        tick();
        ConfigShiftEn = 1'b0;
        m_shadow = {m_shadow[NB-2:0], b};
        if (m_count < NB + 1) m_count++;
    endtask

    task automatic model_commit();
        if (m_count == NB) begin
            for (int k = 0; k < NW; k++) m_mode[k] = 2 * int'(m_shadow[2*k+1]) + int'(m_shadow[2*k]);
            m_loaded = 1'b1;
        end else begin
            m_err = 1'b1;
        end
        m_count = 0;
    endtask

    task automatic commit();
        ConfigCommit = 1'b1;
        tick();
        ConfigCommit = 1'b0;
        model_commit();
    endtask

    // Shift and commit together: the shift must be ignored
    task automatic shift_commit(input logic b);
        ConfigData = b; ConfigShiftEn = 1'b1; ConfigCommit = 1'b1;
        tick();
        ConfigShiftEn = 1'b0; ConfigCommit = 1'b0;
        model_commit();
    endtask

    // First-shifted bit lands at the MSB, so shift wire NW-1 first, high bit first
    task automatic load_modes();
        for (int k = NW - 1; k >= 0; k--) begin
            shift_bit(1'(want[k] >> 1));
            shift_bit(1'(want[k] & 1));
        end
    endtask

    task automatic set_all(input int m);
        for (int k = 0; k < NW; k++) want[k] = m;
    endtask

    task automatic set_inputs(input logic [3:0] a, input logic [7:0] b, input logic [7:0] c,
                              input logic [15:0] d, input logic [15:0] e);
        S1END = a; S2MID = b; S2END = c; S4END = d; SS4END = e;
    endtask

    task automatic apply_table(input int mode);
        for (int t = 0; t < 5; t++) begin
            if (tab[t].mode == mode) begin
                set_inputs(tab[t].s1, tab[t].s2m, tab[t].s2e, tab[t].s4, tab[t].ss4);
                #1;
                check($sformatf("tab%0d:N1BEG", t),  32'(N1BEG),  32'(tab[t].e1));
                check($sformatf("tab%0d:N2BEG", t),  32'(N2BEG),  32'(tab[t].e2));
                check($sformatf("tab%0d:N2BEGb", t), 32'(N2BEGb), 32'(tab[t].e2b));
                check($sformatf("tab%0d:N4BEG", t),  32'(N4BEG),  32'(tab[t].e4));
                check($sformatf("tab%0d:NN4BEG", t), 32'(NN4BEG), 32'(tab[t].ew4));
                check_all($sformatf("tab%0d", t));
            end
        end
    endtask

    initial begin
        tab[0] = '{0, 4'b0011, 8'h01, 8'h0F, 16'h0001, 16'h1234, 4'b1100, 8'h80, 8'hF0, 16'h8000, 16'h2C48};
        tab[1] = '{0, 4'b1000, 8'hA5, 8'h12, 16'hFF00, 16'h8001, 4'b0001, 8'hA5, 8'h48, 16'h00FF, 16'h8001};
        tab[2] = '{1, 4'b0011, 8'h0F, 8'hF0, 16'h0001, 16'hABCD, 4'b0011, 8'h0F, 8'hF0, 16'h0001, 16'hABCD};
        tab[3] = '{1, 4'b0110, 8'h3C, 8'h81, 16'hF00F, 16'h0F0F, 4'b0110, 8'h3C, 8'h81, 16'hF00F, 16'h0F0F};
        tab[4] = '{3, 4'hF, 8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF, 4'h0, 8'h00, 8'h00, 16'h0000, 16'h0000};

        ConfigData = 1'b0; ConfigShiftEn = 1'b0; ConfigCommit = 1'b0;
        set_inputs('0, '0, '0, '0, '0);
        Reset = 1'b1;
        model_reset();
        repeat (2) @(posedge UserCLK);
        #3 Reset = 1'b0;
        #1;

        // Reset state: legacy reversed loopback, nothing loaded
        apply_table(0);
        check("reset:loaded", 32'(ConfigLoaded), 32'd0);
        check("reset:err", 32'(ConfigErr), 32'd0);

        // All straight; outputs stay reversed until the commit edge
        set_all(1);
        load_modes();
        check_all("pre_commit_straight");
        commit();
        check("straight:loaded", 32'(ConfigLoaded), 32'd1);
        apply_table(1);

        // All forced zero
        set_all(3);
        load_modes();
        commit();
        apply_table(3);

        // All registered reversed: one-cycle lag on N1BEG
        set_all(2);
        load_modes();
        commit();
        check_all("reg_rev_first");
        S1END = 4'h0; tick();
        check("reg_rev:step0", 32'(N1BEG), 32'h0);
        S1END = 4'h1; tick();
        check("reg_rev:step1", 32'(N1BEG), 32'h8);
        S1END = 4'h2; tick();
        check("reg_rev:step2", 32'(N1BEG), 32'h4);
        check_all("reg_rev_model");

        // Short load rejected, active unchanged; then a full load is accepted
        set_all(0);
        load_modes();
        commit();
        for (int i = 0; i < NB - 1; i++) shift_bit(1'b1);
        commit();
        check("short:err", 32'(ConfigErr), 32'd1);
        apply_table(0);
        set_all(1);
        load_modes();
        commit();
        check("reload:loaded", 32'(ConfigLoaded), 32'd1);
        check("reload:err_sticky", 32'(ConfigErr), 32'd1);
        apply_table(1);

        // Shift + commit together after exactly NB shifts
        for (int k = 0; k < NW; k++) want[k] = int'($urandom_range(0, 3));
        load_modes();
        shift_commit(1'b1);
        check_all("shift_commit");
        set_all(1);
        load_modes();
        commit();
        check_all("after_shift_commit");

        // Reset mid-shift: asynchronous return to reversed loopback
        for (int k = 0; k < NW; k++) want[k] = int'($urandom_range(0, 3));
        load_modes();
        commit();
        for (int i = 0; i < 50; i++) shift_bit(1'($urandom));
        #2 Reset = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        #1 Reset = 1'b0;
        set_all(1);
        load_modes();
        commit();
        check("post_reset:err", 32'(ConfigErr), 32'd0);
        check_all("post_reset_load");

`ifdef TERM_SM_READBACK_EN
        shift_bit(1'b1);
        for (int i = 0; i < NB - 1; i++) shift_bit(1'b0);
        check("readback:msb", 32'(ConfigDataOut), 32'd1);
        commit();
`endif

        // Randomized modes, occasional bad counts, random traffic
        for (int it = 0; it < 30; it++) begin
            int sel = int'($urandom_range(0, 7));
            if (sel == 0) begin
                for (int i = 0; i < NB - 1; i++) shift_bit(1'($urandom));
            end else if (sel == 1) begin
                for (int i = 0; i < NB + 1; i++) shift_bit(1'($urandom));
            end else if (sel == 2) begin
                for (int i = 0; i < NB + 128; i++) shift_bit(1'($urandom));
            end else begin
                for (int k = 0; k < NW; k++) want[k] = int'($urandom_range(0, 3));
                load_modes();
            end
            commit();
            check_all($sformatf("rnd%0d_commit", it));
            for (int c = 0; c < 8; c++) begin
                set_inputs(4'($urandom), 8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom));
                #1;
                check_all($sformatf("rnd%0d_c%0d", it, c));
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/term_loopback_switch_matrix.md
Name: term_loopback_switch_matrix

Overview:
- Parametrised, configurable successor to the fixed south-terminal loopback switch matrix.
- Turns every south-arriving wire group (single, double-mid, double-end, quad, double-quad) back north.
- Per-wire 2-bit mode selects among:
  - index-reversed loopback
  - straight loopback
  - registered reversed loopback
  - constant 0
- Mode bits load serially into a shadow register and are committed atomically, so routing changes glitch-free.
- Sits at the array edge, below/above terminal tiles of DSP, RAM and LUT columns.

Parameters:
- W1, 4, number of single-hop wires (S1END/N1BEG)
- W2, 8, number of double-hop wires per half (S2MID/S2END, N2BEG/N2BEGb)
- W4, 16, number of quad wires (S4END/N4BEG)
- WW4, 16, number of double-quad wires (SS4END/NN4BEG)
- NoConfigBits, 2*(W1+2*W2+W4+WW4) = 104, mode-register length; derived, not overridable

Ports:
- UserCLK  in  1  fabric clock
- Reset  in  1  asynchronous, active-high reset
- S1END  in  W1  single-hop wire ends from south
- S2MID  in  W2  double-hop mid taps
- S2END  in  W2  double-hop ends
- S4END  in  W4  quad ends
- SS4END  in  WW4  double-quad ends
- N1BEG  out  W1  single-hop begins north
- N2BEG  out  W2  driven from S2MID
- N2BEGb  out  W2  driven from S2END
- N4BEG  out  W4  driven from S4END
- NN4BEG  out  WW4  driven from SS4END
- ConfigData  in  1  serial mode bit
- ConfigShiftEn  in  1  shift ConfigData into shadow register this cycle
- ConfigCommit  in  1  single-cycle pulse; copy shadow to active
- ConfigLoaded  out  1  high once a valid commit has occurred since reset
- ConfigErr  out  1  sticky; commit attempted with bit count != NoConfigBits
- ConfigDataOut  out  1  serial readback (see Optional Feature)

Behaviour:
- Wire ordering: global wire index k = concatenation {S1END, S2MID, S2END, S4END, SS4END}, S1END bit 0 = k0. Active mode bits for wire k are active[2k+1:2k].
- Reversed source: for a group of width W, output bit i takes input bit W-1-i.
- Straight source: output bit i takes input bit i.
- Per-wire modes:
  - 00: reversed, combinational.
  - 01: straight, combinational.
  - 10: reversed, through a UserCLK flop; 1-cycle latency; flop resets to 0.
  - 11: output 0.
- Reset:
  - Shadow, active, bit counter, ConfigLoaded, ConfigErr and all loopback flops go to 0.
  - Reset state is all-mode-00, which reproduces the legacy fixed reversed loopback.
- Shift:
  - On ConfigShiftEn, shadow <= {shadow[NoConfigBits-2:0], ConfigData}.
  - The first-shifted bit ends at the MSB.
  - Bit counter increments, saturating at NoConfigBits+1 (overrun marker).
- Commit, on ConfigCommit pulse:
  - If count == NoConfigBits: active <= shadow next edge, ConfigLoaded <= 1.
  - Else: active unchanged, ConfigErr <= 1.
  - Either way, count <= 0.
- Commit and shift in the same cycle: commit wins. Shift is ignored that cycle (shadow and counter unchanged before the commit check).
- Active modes take effect on outputs the cycle after the commit edge. Registered-mode flops run continuously, so switching into mode 10 yields the previous cycle's input immediately.
- ConfigErr clears only on Reset.
- Reset mid-load discards the partial shadow. Reset mid-operation forces combinational reversed loopback asynchronously.

Optional Feature:
- TERM_SM_READBACK_EN defined: ConfigDataOut = shadow[NoConfigBits-1], allowing daisy-chained readback; each shift presents the next bit.
- Undefined: ConfigDataOut tied 0 and no extra logic.

Test Plan:
- Reset only; S4END=16'h0001, S1END=4'b0011 -> N4BEG=16'h8000, N1BEG=4'b1100 combinationally; ConfigLoaded=0, ConfigErr=0.
- Shift 104 bits of pattern 01 for every wire, then commit; S2MID=8'h0F -> N2BEG=8'h0F from the cycle after commit; ConfigLoaded=1.
- All wires mode 10, committed; S1END steps 0->4'h1->4'h2 on successive edges -> N1BEG shows 0, 4'h8, 4'h4 with one-cycle lag.
- Shift 103 bits then commit -> ConfigErr=1, active unchanged (outputs still reversed loopback); shift 104 more and commit -> accepted, ConfigErr stays 1.
- ConfigShiftEn and ConfigCommit high together after exactly 104 shifts -> commit accepted, shadow not shifted, counter 0; assert Reset mid-shift -> counter 0, outputs revert to mode 00 without clock.
- With TERM_SM_READBACK_EN: shift 1 then 103 zeros -> ConfigDataOut=1 after the 104th shift edge.
